// File: rtl/comparador_serial_izq_der.sv
// Sequential magnitude comparator: scans two K-bit operands MSB-first, P bits per cycle,
// and stops at the first differing chunk. Signed mode biases the sign bit so one unsigned scan serves both.
module comparador_serial_izq_der #(
    parameter int K              = 5,
    parameter int BITS_POR_CICLO = 1,
    localparam int CW            = $clog2(K / BITS_POR_CICLO + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inicio,
    input  logic          con_signo,
    input  logic [K-1:0]  A_valor,
    input  logic [K-1:0]  B_valor,
    output logic          ocupado,
    output logic          listo,
    output logic          A_mayor,
    output logic          B_mayor,
    output logic          iguales,
    output logic [CW-1:0] ciclos
);

    localparam int P = BITS_POR_CICLO;
    localparam int N = K / P;
    localparam logic [K-1:0] BIAS = K'(1) << (K - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARA = 2'd1,
        FIN     = 2'd2
    } estado_t;

    estado_t        estado_r;
    logic [K-1:0]   a_r;
    logic [K-1:0]   b_r;
    logic [CW-1:0]  idx_r;
    logic [P-1:0]   trozo_a_s;
    logic [P-1:0]   trozo_b_s;

    // Operands are shifted left each cycle, so the current chunk is always the top P bits.
    assign trozo_a_s = a_r[K-1 -: P];
    assign trozo_b_s = b_r[K-1 -: P];

    // Handshake FSM with registered result flags, chunk counter and operand shifters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado_r <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            idx_r    <= '0;
            ocupado  <= 1'b0;
            listo    <= 1'b0;
            A_mayor  <= 1'b0;
            B_mayor  <= 1'b0;
            iguales  <= 1'b0;
            ciclos   <= '0;
        end else begin
            case (estado_r)
                IDLE: begin
                    listo <= 1'b0;
                    if (inicio) begin
                        a_r      <= con_signo ? (A_valor ^ BIAS) : A_valor;
                        b_r      <= con_signo ? (B_valor ^ BIAS) : B_valor;
                        idx_r    <= '0;
                        A_mayor  <= 1'b0;
                        B_mayor  <= 1'b0;
                        iguales  <= 1'b0;
                        ciclos   <= '0;
                        ocupado  <= 1'b1;
                        estado_r <= COMPARA;
                    end else begin
                        ocupado  <= 1'b0;
                    end
                end
                COMPARA: begin
                    if (trozo_a_s != trozo_b_s) begin
                        A_mayor  <= (trozo_a_s > trozo_b_s);
                        B_mayor  <= (trozo_a_s < trozo_b_s);
                        ciclos   <= idx_r + CW'(1);
                        listo    <= 1'b1;
                        estado_r <= FIN;
                    end else if (idx_r == CW'(N - 1)) begin
                        iguales  <= 1'b1;
                        ciclos   <= CW'(N);
                        listo    <= 1'b1;
                        estado_r <= FIN;
                    end else begin
                        idx_r    <= idx_r + CW'(1);
                        a_r      <= a_r << P;
                        b_r      <= b_r << P;
                    end
                end
                FIN: begin
                    listo    <= 1'b0;
                    ocupado  <= 1'b0;
                    estado_r <= IDLE;
                end
                default: begin
                    listo    <= 1'b0;
                    ocupado  <= 1'b0;
                    estado_r <= IDLE;
                end
            endcase
        end
    end

endmodule
